// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM states, mode encodings and chip-select width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_DONE
  } spi_state_t;

  // Mode encodings as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Width of a chip-select index; never narrower than one bit
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: strobes o_tick on the last cycle of every H = div+1 cycle phase.
// Latency: first tick H cycles after load; o_lead marks ticks that start a leading SCLK edge.
// Backpressure: none; counts only while i_run is high, reloads on i_load.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_lead
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_par;

  // Phase counter; parity of completed phases gives leading/trailing (tick 0 is leading)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= '0;
      r_par <= 1'b0;
    end else if (i_run) begin
      if (r_cnt == r_div) begin
        r_cnt <= '0;
        r_par <= ~r_par;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign o_tick = i_run && (r_cnt == r_div);
  assign o_lead = ~r_par;

endmodule

// File: rtl/spi_master_param.sv
// SPI master: parametrised word width, SCLK divider, all CPOL/CPHA modes, multiple chip selects.
// Latency: done pulses (2*DATA_W+2)*(clk_div+1)+1 cycles after start is accepted; all outputs registered.
// Backpressure: start taken only when idle or in the done cycle; requests while busy are dropped.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DIV_W  = 8,
  parameter int  NUM_CS = 2,
  localparam int CS_W   = cs_width(NUM_CS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic [CS_W-1:0]   i_cs_sel,
  input  logic              i_cs_hold,
  input  logic              i_cs_release,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [NUM_CS-1:0] o_cs_n
);

  localparam int HC_W = $clog2(2 * DATA_W);

  spi_state_t        r_state;
  spi_state_t        w_state_nxt;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_hold;
  logic [NUM_CS-1:0] r_cs_n;
  logic [NUM_CS-1:0] w_cs_dec;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic [HC_W-1:0]   r_hcnt;
  logic              w_tick;
  logic              w_lead;
  logic              w_accept;
  logic              w_release;
  logic              w_run;
  logic              w_last_half;
  logic              w_final_edge;
  logic              w_edge;
  logic              w_shift;
  logic              w_sample;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_accept),
    .i_run  (w_run),
    .i_div  (i_clk_div),
    .o_tick (w_tick),
    .o_lead (w_lead)
  );

  // Active-low one-hot select; an out-of-range index asserts nothing
  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (i_cs_sel == CS_W'(i)) w_cs_dec[i] = 1'b0;
    end
  end

  // Handshake decode and per-tick edge action select
  always_comb begin
    w_accept     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
    w_release    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && !i_start && i_cs_release;
    w_run        = (r_state == ST_LEAD) || (r_state == ST_XFER) || (r_state == ST_TRAIL);
    w_last_half  = (r_hcnt == HC_W'(2 * DATA_W - 1));
    w_final_edge = (r_hcnt == HC_W'(2 * DATA_W - 2));
    w_edge       = w_tick && ((r_state == ST_LEAD) || ((r_state == ST_XFER) && !w_last_half));
    // cpha=1 drives on leading edges; cpha=0 drives on trailing edges except the last one
    w_shift      = w_edge && (w_lead ? r_cpha : (!r_cpha && !w_final_edge));
    w_sample     = w_edge && (w_lead ^ r_cpha);
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_LEAD;
      ST_LEAD:  if (w_tick) w_state_nxt = ST_XFER;
      ST_XFER:  if (w_tick && w_last_half) w_state_nxt = ST_TRAIL;
      ST_TRAIL: if (w_tick) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = i_start ? ST_LEAD : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: config latch, SCLK/MOSI/CS drive, shift registers and done handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_hold    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_hcnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cpol <= i_cpol;
        r_cpha <= i_cpha;
        r_hold <= i_cs_hold;
        r_sclk <= i_cpol;
        r_busy <= 1'b1;
        r_cs_n <= w_cs_dec;
        r_hcnt <= '0;
        // cpha=0 must present the MSB before the first (sampling) edge
        if (!i_cpha) begin
          r_mosi <= i_tx_data[DATA_W-1];
          r_tx   <= {i_tx_data[DATA_W-2:0], 1'b0};
        end else begin
          r_tx   <= i_tx_data;
        end
      end
      if (w_release) r_cs_n <= '1;
      if (w_edge) r_sclk <= ~r_sclk;
      if (w_shift) begin
        r_mosi <= r_tx[DATA_W-1];
        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
      end
      if (w_sample) r_rx <= {r_rx[DATA_W-2:0], i_miso};
      if (w_tick && (r_state == ST_XFER)) begin
        if (w_last_half) r_sclk <= r_cpol;
        else             r_hcnt <= r_hcnt + HC_W'(1);
      end
      if (w_tick && (r_state == ST_TRAIL)) begin
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_rx_data <= r_rx;
        if (!r_hold) r_cs_n <= '1;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_rx_data = r_rx_data;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
`timescale 1ns/1ps
// Bench for spi_master_param: 8-bit/2-CS instance with a mode-aware slave, plus a 16-bit/3-CS instance.
// Latency: checks done cycle, SCLK phase lengths, CS/busy windows and rx words against a scoreboard.
// Backpressure: exercises start/cs_release while busy, back-to-back held frames and mid-transfer reset.
module tb_spi_master_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit instance
  logic       start8, cpol8, cpha8, hold8, rel8, miso8, sel8;
  logic [7:0] tx8, div8;
  logic       busy8, done8, sclk8, mosi8;
  logic [7:0] rx8;
  logic [1:0] csn8;

  // 16-bit instance
  logic        start16, cpol16, cpha16, hold16, rel16;
  logic [15:0] tx16;
  logic [7:0]  div16;
  logic [1:0]  sel16;
  logic        busy16, done16, sclk16, mosi16;
  logic [15:0] rx16;
  logic [2:0]  csn16;

  spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_CS(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_tx_data(tx8), .i_cpol(cpol8),
    .i_cpha(cpha8), .i_clk_div(div8), .i_cs_sel(sel8), .i_cs_hold(hold8),
    .i_cs_release(rel8), .o_busy(busy8), .o_done(done8), .o_rx_data(rx8),
    .o_sclk(sclk8), .o_mosi(mosi8), .i_miso(miso8), .o_cs_n(csn8)
  );

  spi_master_param #(.DATA_W(16), .DIV_W(8), .NUM_CS(3)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(start16), .i_tx_data(tx16), .i_cpol(cpol16),
    .i_cpha(cpha16), .i_clk_div(div16), .i_cs_sel(sel16), .i_cs_hold(hold16),
    .i_cs_release(rel16), .o_busy(busy16), .o_done(done16), .o_rx_data(rx16),
    .o_sclk(sclk16), .o_mosi(mosi16), .i_miso(mosi16), .o_cs_n(csn16)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  sb8[$];
  logic [15:0] sb16[$];
  logic [1:0]  cs_now;

  // Slave model for the 8-bit instance (loop8 selects plain loopback instead)
  logic       loop8 = 1'b1, cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic [7:0] slave_word = 8'h00, sl_sh = 8'h00;
  logic       sl_prev_busy = 1'b0, sl_prev_sclk = 1'b0, miso_s = 1'b0;

  assign miso8 = loop8 ? mosi8 : miso_s;

  always @(negedge clk) begin
    if (busy8 === 1'b1 && !sl_prev_busy) begin
      sl_sh = slave_word;
      if (!cfg_cpha) begin
        miso_s = sl_sh[7];
        sl_sh  = {sl_sh[6:0], 1'b0};
      end
    end else if (busy8 === 1'b1 && (sclk8 !== sl_prev_sclk) &&
                 ((sclk8 !== cfg_cpol) == cfg_cpha)) begin
      miso_s = sl_sh[7];
      sl_sh  = {sl_sh[6:0], 1'b0};
    end
    sl_prev_busy = (busy8 === 1'b1);
    sl_prev_sclk = sclk8;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic       sel;
    logic       hold;
    logic       rel;
    logic       loop;
    logic [7:0] tx;
    logic [7:0] slave;
    int         inj;
    logic [7:0] exp_rx;
    int         exp_done;
    logic [1:0] exp_cs_end;
  } vec_t;

  vec_t vt[8];

  // One transfer on the 8-bit instance, monitored cycle by cycle
  task automatic apply(input vec_t v);
    int         n, rises, terr, last_chg;
    logic       prev;
    logic [1:0] cs_exp;
    logic [7:0] rx_start, got;
    @(negedge clk);
    chk("idle_busy", busy8, 1'b0);
    chk("idle_done", done8, 1'b0);
    chk("cs_idle", csn8, cs_now);
    cfg_cpol = v.mode[1]; cfg_cpha = v.mode[0]; loop8 = v.loop; slave_word = v.slave;
    cpol8 = v.mode[1]; cpha8 = v.mode[0]; div8 = v.div; sel8 = v.sel; hold8 = v.hold;
    tx8 = v.tx; rel8 = v.rel; start8 = 1'b1;
    sb8.push_back(v.exp_rx);
    cs_exp = ~(2'b01 << v.sel);
    rx_start = rx8;
    n = 0; rises = 0; terr = 0; last_chg = 1; prev = v.mode[1];
    do begin
      @(negedge clk);
      n++;
      start8 = (n == v.inj);
      rel8   = (n == v.inj);
      tx8    = (n == v.inj) ? 8'hFF : v.tx;
      if (sclk8 !== prev) begin
        if (n - last_chg != int'(v.div) + 1) terr++;
        if (sclk8 === 1'b1) rises++;
        prev = sclk8;
        last_chg = n;
      end
      if (done8 !== 1'b1) begin
        if (busy8 !== 1'b1 || csn8 !== cs_exp || rx8 !== rx_start) terr++;
      end
    end while (done8 !== 1'b1 && n < 3000);
    chk("done_cycle", n, v.exp_done);
    chk("busy_at_done", busy8, 1'b0);
    chk("sclk_rises", rises, 8);
    chk("timing_errs", terr, 0);
    chk("cs_at_done", csn8, v.exp_cs_end);
    if (sb8.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL rx_data: scoreboard empty, got 0x%0h", rx8);
    end else begin
      got = sb8.pop_front();
      chk("rx_data", rx8, got);
    end
    cs_now = v.exp_cs_end;
  endtask

  // One mode-1 transfer on the 16-bit instance with clk_div=0
  task automatic run16(input logic [15:0] tx, input logic [1:0] sel, input logic [2:0] cs_exp);
    int          n, rises, terr;
    logic        prev;
    logic [15:0] got;
    @(negedge clk);
    tx16 = tx; sel16 = sel; start16 = 1'b1;
    sb16.push_back(tx);
    n = 0; rises = 0; terr = 0; prev = 1'b0;
    do begin
      @(negedge clk);
      n++;
      start16 = 1'b0;
      if (sclk16 !== prev) begin
        if (sclk16 === 1'b1) rises++;
        prev = sclk16;
      end
      if (done16 !== 1'b1 && (busy16 !== 1'b1 || csn16 !== cs_exp)) terr++;
    end while (done16 !== 1'b1 && n < 3000);
    chk("w16_done_cycle", n, 35);
    chk("w16_sclk_rises", rises, 16);
    chk("w16_timing_errs", terr, 0);
    chk("w16_cs_at_done", csn16, 3'b111);
    got = sb16.pop_front();
    chk("w16_rx_data", rx16, got);
  endtask

  initial begin
    int ndone;
    //             mode       div    sel   hold  rel   loop  tx     slave  inj exp_rx done end_cs
    vt[0] = '{SPI_MODE0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 0, 8'hA5, 19, 2'b11};
    vt[1] = '{SPI_MODE3, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h3C, 0, 8'h3C, 73, 2'b11};
    vt[2] = '{SPI_MODE1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h96, 8'h00, 0, 8'h96, 37, 2'b11};
    vt[3] = '{SPI_MODE2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 8'hC3, 0, 8'hC3, 19, 2'b11};
    vt[4] = '{SPI_MODE0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 0, 8'h12, 19, 2'b01};
    vt[5] = '{SPI_MODE0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 8'h00, 0, 8'h34, 19, 2'b11};
    vt[6] = '{SPI_MODE1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7E, 8'h00, 5, 8'h7E, 55, 2'b10};
    vt[7] = '{SPI_MODE0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 8'h00, 0, 8'h81, 19, 2'b11};

    rst = 1'b1;
    start8 = 0; cpol8 = 0; cpha8 = 0; hold8 = 0; rel8 = 0; sel8 = 0; tx8 = 0; div8 = 0;
    start16 = 0; cpol16 = 0; cpha16 = 1; hold16 = 0; rel16 = 0; sel16 = 0; tx16 = 0; div16 = 0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk8, 1'b0);
    chk("rst_mosi", mosi8, 1'b0);
    chk("rst_cs_n", csn8, 2'b11);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_rx", rx8, 8'h00);
    chk("rst_cs_n16", csn16, 3'b111);
    rst = 1'b0;
    cs_now = 2'b11;

    for (int i = 0; i < 7; i++) apply(vt[i]);

    // Idle cs_release drops the line held by the previous frame
    @(negedge clk);
    chk("held_cs", csn8, 2'b10);
    rel8 = 1'b1;
    @(negedge clk);
    rel8 = 1'b0;
    chk("release_cs", csn8, 2'b11);
    cs_now = 2'b11;

    // Reset while the fifth bit is on the wire
    cfg_cpol = 0; cfg_cpha = 0; loop8 = 1;
    cpol8 = 0; cpha8 = 0; div8 = 0; sel8 = 1; hold8 = 1; tx8 = 8'hFF; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (9) @(negedge clk);
    chk("pre_rst_sclk", sclk8, 1'b1);
    chk("pre_rst_cs", csn8, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sclk", sclk8, 1'b0);
    chk("abort_mosi", mosi8, 1'b0);
    chk("abort_cs_n", csn8, 2'b11);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_rx", rx8, 8'h00);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    cs_now = 2'b11;

    apply(vt[7]);

    run16(16'hBEEF, 2'd0, 3'b110);
    run16(16'h1234, 2'd3, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
